// File: rtl/uart_pkg.sv
// Package shared by the UART receiver slice.
// Holds the receiver state encoding, the bit positions of the debug
// probe bus and the helper that derives the bit period from clock and baud.
package uart_pkg;

    // Receiver states; the encoding is visible on debug[1:0].
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Debug bus layout: {frame_err_sticky, overrun_sticky, state[1:0]}.
    localparam int DBG_FERR_BIT = 3;
    localparam int DBG_OVR_BIT  = 2;
    localparam int DBG_ST_HI    = 1;
    localparam int DBG_ST_LO    = 0;

    // Number of data bits in an 8N1 frame.
    localparam int DATA_BITS = 8;

    // Sys_clk cycles per serial bit (integer division).
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART receiver.
// Counts down to zero and raises tick while the count is zero, then
// reloads a full bit period so consecutive samples stay one bit apart.
// Ports:
//   sys_clk    in  system clock, rising edge
//   rst        in  synchronous active-high reset
//   load_half  in  load half a bit period (start-bit centring); wins over run
//   run        in  advance the count; tick is only raised while running
//   tick       out high in the cycle the count sits at zero
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic load_half,
    input  logic run,
    output logic tick
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_RELOAD = TW'(CLKS_PER_BIT - 1);
    // Loading HALF-1 puts the first tick exactly CLKS_PER_BIT/2 cycles after the load.
    localparam logic [TW-1:0] HALF_RELOAD = TW'((CLKS_PER_BIT / 2) - 1);
    localparam logic [TW-1:0] CNT_ZERO    = {TW{1'b0}};

    logic [TW-1:0] cnt_r;
    logic          at_zero_s;

    // Zero detect of the down-counter.
    always_comb begin
        at_zero_s = (cnt_r == CNT_ZERO);
    end

    // Down-counter with half-period load and full-period auto reload.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (load_half) begin
            cnt_r <= HALF_RELOAD;
        end else if (run) begin
            if (at_zero_s) begin
                cnt_r <= FULL_RELOAD;
            end else begin
                cnt_r <= cnt_r - {{(TW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Tick only means something while a frame is being timed.
    always_comb begin
        tick = run & at_zero_s;
    end

endmodule

// File: rtl/uart_rx_dbg.sv
// UART receiver, 8N1, LSB first, sys_clk domain, with logic-analyzer debug bus.
// Synchronises the pin, validates the start bit at mid-bit, samples data and
// stop bits at bit centres, and hands bytes out over a valid/ready handshake.
// Ports:
//   sys_clk    in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rx_i       in   asynchronous serial input, idle high
//   rx_data    out  received byte, stable while rx_valid=1
//   rx_valid   out  byte available, held until accepted
//   rx_ready   in   consumer accepts when rx_valid & rx_ready
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, byte completed while previous one unaccepted
//   debug      out  {frame_err_sticky, overrun_sticky, state[1:0]}
module uart_rx_dbg
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 27_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic [3:0] debug
);

    // Pin synchroniser and edge history.
    logic       sync1_r;
    logic       rxs_r;
    logic       prev_r;
    logic [1:0] fill_r;
    logic       fall_s;

    // FSM and datapath.
    rx_state_e  state_r;
    rx_state_e  state_nx_s;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       tick_s;

    // FSM controls.
    logic       load_half_s;
    logic       timer_run_s;
    logic       shift_en_s;
    logic       stop_ok_s;
    logic       stop_bad_s;

    // Output registers.
    logic [7:0] rx_data_r;
    logic       rx_valid_r;
    logic       frame_err_r;
    logic       overrun_r;
    logic       fe_sticky_r;
    logic       ov_sticky_r;

    // Two-flop synchroniser plus previous-value flop for edge detection.
    // fill_r keeps prev_r at 0 until the whole pipeline holds real pin samples,
    // so the forced-high reset value can never fake a falling edge when the
    // line is already low as reset releases.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            prev_r  <= 1'b0;
            fill_r  <= 2'b00;
        end else begin
            sync1_r <= rx_i;
            rxs_r   <= sync1_r;
            prev_r  <= fill_r[1] ? rxs_r : 1'b0;
            fill_r  <= {fill_r[0], 1'b1};
        end
    end

    // Falling edge of the synchronised line.
    always_comb begin
        fall_s = prev_r & ~rxs_r;
    end

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .load_half (load_half_s),
        .run       (timer_run_s),
        .tick      (tick_s)
    );

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    // A high line at mid start bit was only a glitch.
                    state_nx_s = rxs_r ? ST_IDLE : ST_DATA;
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s && (bit_cnt_r == 3'(DATA_BITS - 1))) begin
                    state_nx_s = ST_STOP;
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_STOP: begin
                // Leaving at mid stop bit lets the next start edge be caught early.
                if (tick_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: timer control, shift enable and stop-bit verdicts.
    always_comb begin
        load_half_s = 1'b0;
        timer_run_s = 1'b0;
        shift_en_s  = 1'b0;
        stop_ok_s   = 1'b0;
        stop_bad_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_half_s = fall_s;
            end
            ST_START: begin
                timer_run_s = 1'b1;
            end
            ST_DATA: begin
                timer_run_s = 1'b1;
                shift_en_s  = tick_s;
            end
            ST_STOP: begin
                timer_run_s = 1'b1;
                stop_ok_s   = tick_s & rxs_r;
                stop_bad_s  = tick_s & ~rxs_r;
            end
            default: begin
                timer_run_s = 1'b0;
            end
        endcase
    end

    // Bit counter and LSB-first shift register.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            if (load_half_s) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (shift_en_s) begin
                shift_r <= {rxs_r, shift_r[7:1]};
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Output byte register, handshake, error pulses and sticky flags.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            fe_sticky_r <= 1'b0;
            ov_sticky_r <= 1'b0;
        end else begin
            frame_err_r <= stop_bad_s;
            overrun_r   <= stop_ok_s & rx_valid_r & ~rx_ready;
            if (stop_bad_s) begin
                fe_sticky_r <= 1'b1;
            end else begin
                fe_sticky_r <= fe_sticky_r;
            end
            if (stop_ok_s & rx_valid_r & ~rx_ready) begin
                ov_sticky_r <= 1'b1;
            end else begin
                ov_sticky_r <= ov_sticky_r;
            end
            // A new byte may replace one that is being accepted in this same cycle.
            if (stop_ok_s && (!rx_valid_r || rx_ready)) begin
                rx_data_r  <= shift_r;
                rx_valid_r <= 1'b1;
            end else if (rx_valid_r && rx_ready) begin
                rx_data_r  <= rx_data_r;
                rx_valid_r <= 1'b0;
            end else begin
                rx_data_r  <= rx_data_r;
                rx_valid_r <= rx_valid_r;
            end
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        rx_data                   = rx_data_r;
        rx_valid                  = rx_valid_r;
        frame_err                 = frame_err_r;
        overrun                   = overrun_r;
        debug[DBG_FERR_BIT]       = fe_sticky_r;
        debug[DBG_OVR_BIT]        = ov_sticky_r;
        debug[DBG_ST_HI:DBG_ST_LO] = state_r;
    end

endmodule

// File: tb/tb_uart_rx_dbg.sv
// Self-checking bench for uart_rx_dbg: serial frames are generated at the bit
// level; expected bytes are queued at frame issue and popped by a monitor on
// every accepted handshake; error pulses are counted against expectations.
module tb_uart_rx_dbg;

    localparam int CPB = 234;
    // Pin fall -> 2 sync flops -> edge seen by IDLE -> half bit -> 8 data + stop.
    localparam int LAT = 2 + 1 + CPB / 2 + 9 * CPB;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic [3:0] debug;

    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  exp_q[$];
    int          fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
    longint      cyc = 0;
    longint      start_cyc = 0;
    longint      rise_cyc = 0;
    logic        prev_valid = 1'b0;
    logic        prev_hold  = 1'b0;
    logic [7:0]  held_data  = 8'h00;

    uart_rx_dbg dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .rx_i      (rx_i),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .debug     (debug)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and counts pulses.
    always @(negedge sys_clk) begin
        if (rst !== 1'b1) begin
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            if (prev_hold) begin
                check("valid_held", {31'd0, rx_valid}, 32'd1);
                check("data_held", {24'd0, rx_data}, {24'd0, held_data});
            end
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
            prev_hold = rx_valid && !rx_ready;
            held_data = rx_data;
        end else begin
            prev_hold = 1'b0;
        end
        prev_valid = rx_valid;
    end

    // Hold the line at one level for a full bit; entered and left at posedge+1.
    task automatic hold_bit(input logic v);
        rx_i = v;
        repeat (CPB) @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Reference rules: good stop -> byte delivered unless one is still waiting
    // unaccepted with ready low (then overrun); bad stop -> frame error only.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        if (!stop) fe_exp++;
        else if (!rx_ready && exp_q.size() != 0) ov_exp++;
        else exp_q.push_back(b);
        start_cyc = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop);
        rx_i = 1'b1;
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_start;
        rst = 1'b1;
        rx_i = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_debug", {28'd0, debug}, 32'd0);
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        idle(10);

        // Single byte, latency check.
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'(LAT));
        check("a5_valid_low", {31'd0, rx_valid}, 32'd0);
        check("a5_debug", {28'd0, debug}, 32'd0);

        // Short low glitch: false start.
        saw_start = 1'b0;
        rx_i = 1'b0;
        repeat (60) @(posedge sys_clk);
        #1;
        rx_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (debug[1:0] == 2'd1) saw_start = 1'b1;
        end
        @(posedge sys_clk);
        #1;
        check("glitch_start_seen", {31'd0, saw_start}, 32'd1);
        check("glitch_idle", {30'd0, debug[1:0]}, 32'd0);
        check("glitch_ferr", 32'(fe_seen), 32'd0);

        // Bad stop bit.
        send_frame(8'h3C, 1'b0);
        idle(20);
        check("ferr_count", 32'(fe_seen), 32'd1);
        check("ferr_sticky", {31'd0, debug[3]}, 32'd1);
        check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);

        // Overrun with consumer stalled.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(20);
        check("ovr_data", {24'd0, rx_data}, 32'h11);
        check("ovr_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_count", 32'(ov_seen), 32'd1);
        check("ovr_sticky", {31'd0, debug[2]}, 32'd1);
        rx_ready = 1'b1;
        idle(3);
        check("ovr_drained", {31'd0, rx_valid}, 32'd0);
        check("ovr_q_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 4 (line low since start bit).
        rx_i = 1'b0;
        repeat (CPB * 5 + 100) @(posedge sys_clk);
        #1;
        check("mid_state_data", {30'd0, debug[1:0]}, 32'd2);
        rst = 1'b1;
        rx_i = 1'b1;
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        check("rst_mid_debug", {28'd0, debug}, 32'd0);
        check("rst_mid_valid", {31'd0, rx_valid}, 32'd0);
        idle(20);
        send_frame(8'h5A, 1'b1);
        idle(20);
        check("post_rst_q_empty", 32'(exp_q.size()), 32'd0);

        // Randomised frames with occasional bad stop bits and random gaps.
        for (int k = 0; k < 8; k++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
            idle($urandom_range(0, 50));
        end
        idle(20);

        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        check("final_ferr", 32'(fe_seen), 32'(fe_exp));
        check("final_ovr", 32'(ov_seen), 32'(ov_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
